// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the async-FIFO read-side drain logic.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } rd_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register FIFO that absorbs the FIFO's one-cycle read latency.
// Entry 0 is the head, so out_data is a plain register.
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] tail;

  // NOTE: both entries are reset because the head drives out_data, which must read 0 after reset.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == '0) head <= din;
          else           tail <= din;
          occ <= occ + 1'b1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 1'b1;
        end
        2'b11: begin
          // Occupancy unchanged; the incoming word lands behind whatever remains.
          if (occ == OCC_WIDTH'(1)) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain burst consumer: drains len words from the FIFO read port onto
// a valid/ready stream at one word per cycle, through a 2-entry skid buffer.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  empty,
  input  logic                  underflow,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  rd_count
);

  rd_state_e             state, state_nxt;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [OCC_WIDTH-1:0]  occ;
  logic                  inflight;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  accept;
  logic [2:0]            slots;

  assign accept    = (state == IDLE) && start;
  assign pop       = out_valid && out_ready;
  assign drop      = (state == READ) && underflow;
  assign push      = inflight && !drop;
  assign out_valid = (occ != '0);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Buffer occupancy once this cycle's in-flight word lands and any pop retires.
  assign slots = 3'(occ) + 3'(inflight) - 3'(pop);

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .rd_clk (rd_clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .din    (rdata),
    .occ    (occ),
    .head   (out_data)
  );

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : READ;
      end
      READ: begin
        if (underflow) begin
          state_nxt = FLUSH;
        end else begin
          rd_en = !empty && (remaining != '0) && (slots < 3'(SKID_DEPTH));
          if ((remaining == '0) || (rd_en && (remaining == LEN_WIDTH'(1))))
            state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (!inflight && (slots == '0)) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
      remaining <= '0;
      rd_count <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;

      if (accept)     remaining <= len;
      else if (drop)  remaining <= '0;
      else if (rd_en) remaining <= remaining - LEN_WIDTH'(1);

      if (accept)   rd_count <= '0;
      else if (pop) rd_count <= rd_count + LEN_WIDTH'(1);

      if (accept)    err <= 1'b0;
      else if (drop) err <= 1'b1;
    end
  end

endmodule
